// File: rtl/mem_space_arbiter.sv
// rtl/mem_space_arbiter.sv - two-master round-robin arbiter onto the unified memory-space slave port
module mem_space_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  grant_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    // 1 means m1 won the most recent contended arbitration
    logic            last_grant;

    logic            pick_m1;
    logic            timeout;
    logic            resp_ack;
    logic            resp_err;
    logic            busy;

    // Arbitration choice and response qualification for the current cycle
    always_comb begin
        pick_m1  = (m0_stb_i && m1_stb_i) ? ~last_grant : m1_stb_i;
        busy     = (state == BUSY);
        timeout  = (wd_cnt == WD_LAST);
        // A real slave response always beats the watchdog; error beats ack
        resp_ack = busy && s_ack_i && !s_err_i;
        resp_err = busy && (s_err_i || (timeout && !s_ack_i));
    end

    // Completion is steered only to the current owner; read data is gated with ack
    always_comb begin
        m0_ack_o  = resp_ack && grant_o[0];
        m1_ack_o  = resp_ack && grant_o[1];
        m0_err_o  = resp_err && grant_o[0];
        m1_err_o  = resp_err && grant_o[1];
        m0_data_o = m0_ack_o ? s_data_i : 32'h0;
        m1_data_o = m1_ack_o ? s_data_i : 32'h0;
    end

    // Grant/hold FSM: latch the winner's request, hold it until response or watchdog
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            s_stb_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= 32'h0;
            s_data_o   <= 32'h0;
            s_sel_o    <= 4'h0;
            grant_o    <= 2'b00;
            wd_cnt     <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_stb_i || m1_stb_i) begin
                        // Only a contended grant moves the round-robin pointer
                        if (m0_stb_i && m1_stb_i) begin
                            last_grant <= pick_m1;
                        end
                        s_we_o   <= pick_m1 ? m1_we_i   : m0_we_i;
                        s_addr_o <= pick_m1 ? m1_addr_i : m0_addr_i;
                        s_data_o <= pick_m1 ? m1_data_i : m0_data_i;
                        s_sel_o  <= pick_m1 ? m1_sel_i  : m0_sel_i;
                        grant_o  <= pick_m1 ? 2'b10 : 2'b01;
                        s_stb_o  <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ack_i || s_err_i || timeout) begin
                        s_stb_o <= 1'b0;
                        grant_o <= 2'b00;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_space_arbiter.md
# mem_space_arbiter

Two-master, one-slave bus arbiter that shares the unified memory space (flash and RAM behind the memory-space controller) between the instruction-fetch port and the data load/store port. It accepts requests on a strobe/ack handshake and grants round-robin when both ports request at once. It holds the granted request stable on the single slave port until acknowledgement. A watchdog aborts any slave transaction that never completes. It sits between the CPU core's two bus masters and the memory-space controller that drives the flash and RAM devices.

## Interface
- TIMEOUT_CYCLES, 1024: cycles in BUSY without s_ack_i/s_err_i before abort; must be ≥2.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- m0_stb_i  in  1  instruction port request; held high until m0_ack_o or m0_err_o.
- m0_we_i  in  1  instruction port write enable.
- m0_addr_i  in  32  instruction port byte address.
- m0_data_i  in  32  instruction port write data.
- m0_sel_i  in  4  instruction port byte enables.
- m0_data_o  out  32  instruction port read data, valid with m0_ack_o.
- m0_ack_o  out  1  instruction port completion, one-cycle pulse.
- m0_err_o  out  1  instruction port error, one-cycle pulse.
- m1_*: data port, identical set to m0_*.
- s_stb_o  out  1  slave request.
- s_we_o, s_addr_o[31:0], s_data_o[31:0], s_sel_o[3:0]  out  slave request fields.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave completion.
- s_err_i  in  1  slave error.
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 0 when idle.

## Operation
- States: IDLE, BUSY.
- IDLE, no stb: stay in IDLE; s_stb_o = 0, grant_o = 0.
- IDLE, exactly one stb: grant that master.
- IDLE, both stb: grant the master not in last_grant; then update last_grant.
- On grant: register we/addr/data/sel into the slave fields, set s_stb_o = 1 and grant_o, clear the watchdog, go to BUSY.
- BUSY: slave fields and s_stb_o held constant. The watchdog increments each cycle.
- BUSY with s_err_i: pulse err_o to the granted master.
- BUSY with s_ack_i only: pulse ack_o to the granted master and drive data_o = s_data_i.
- In both cases above, on the next edge: s_stb_o = 0, grant_o = 0, go to IDLE.
- s_err_i and s_ack_i together: err wins; ack_o is not pulsed.
- Watchdog reaches TIMEOUT_CYCLES-1 with no ack/err: pulse err_o to the granted master, drop s_stb_o, go to IDLE.
- Ack/err arriving on the same cycle as timeout: the slave response wins.
- The non-granted master's ack_o/err_o stay 0. Its data_o is 0 whenever its ack_o is 0.
- The m*_i fields are sampled only at grant. Master changes during BUSY are ignored.
- last_grant resets to m1, so m0 wins the first contention.

## Timing
- Reset (asynchronous, immediate): state IDLE, s_stb_o = 0, all slave fields 0, all ack/err/data outputs 0, grant_o = 0, watchdog 0, last_grant = m1.
- Reset mid-BUSY aborts the transaction with no ack/err to the master.
- Grant latency: stb sampled high at edge N → s_stb_o high after edge N (visible in cycle N+1).
- Completion: s_ack_i/s_err_i in cycle K → master ack_o/err_o combinationally in cycle K → s_stb_o low in cycle K+1.
- Back-to-back: next grant evaluated in cycle K+1, so s_stb_o is high again in K+2. There is a minimum one idle slave cycle between transactions.
- Masters deassert stb in the cycle after ack/err. A stb still high in cycle K+1 is treated as a new request.
- Timeout: s_stb_o high for exactly TIMEOUT_CYCLES cycles; err_o pulses in the last of them.

## Test plan
- Reset: hold rst_n_i = 0 with random inputs → all outputs 0. Assert rst_n_i = 0 mid-BUSY → s_stb_o drops without waiting for a clock.
- Single read: m0 reads 0x0000_1000; slave acks 3 cycles after s_stb_o with 0xDEADBEEF → s_addr_o = 0x0000_1000, m0_ack_o one cycle, m0_data_o = 0xDEADBEEF, m1_ack_o = 0.
- Contention: m0 and m1 assert stb on the same cycle, m1 writes 0x1234_5678 with sel 0xF to 0x0200_0010 → m0 served first. m1 granted in the cycle after m0's ack, with s_stb_o high 2 cycles after m0's ack and s_data_o = 0x1234_5678. A repeat contention grants m1 first.
- Sustained contention: both masters re-request immediately, 8 transactions → strict alternation m0, m1, m0, ….
- Error: slave asserts s_err_i and s_ack_i together on an m1 request → m1_err_o = 1, m1_ack_o = 0.
- Timeout with TIMEOUT_CYCLES = 8 and a silent slave → s_stb_o high 8 cycles, m0_err_o pulses in cycle 8. A following m1 request is granted normally.
